// File: rtl/kart_controller_if.sv
// Kart controller bundle: frame control, buttons, trig/track ROM ports and committed kart state.
// master = frame/ROM environment, slave = kart_controller.
interface kart_controller_if;
    logic               frame_tick;
    logic               btn_left;
    logic               btn_right;
    logic               btn_accel;
    logic               btn_brake;
    logic        [8:0]  trig_cos_addr;
    logic        [8:0]  trig_sin_addr;
    logic signed [10:0] cos_in;
    logic signed [10:0] sin_in;
    logic        [7:0]  track_addr;
    logic        [3:0]  terrain_in;
    logic        [3:0]  obstacle_in;
    logic        [8:0]  direction;
    logic        [10:0] player_x;
    logic        [10:0] player_y;
    logic        [6:0]  speed_out;
    logic        [3:0]  lap_count;
    logic               spinning;
    logic               update_done;

    modport master (
        output frame_tick, btn_left, btn_right, btn_accel, btn_brake,
        output cos_in, sin_in, terrain_in, obstacle_in,
        input  trig_cos_addr, trig_sin_addr, track_addr,
        input  direction, player_x, player_y, speed_out, lap_count, spinning, update_done
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_accel, btn_brake,
        input  cos_in, sin_in, terrain_in, obstacle_in,
        output trig_cos_addr, trig_sin_addr, track_addr,
        output direction, player_x, player_y, speed_out, lap_count, spinning, update_done
    );
endinterface

// File: rtl/kart_controller.sv
// Kart state: per frame_tick turn, read trig ROMs, update speed/position, sample track ROMs, commit atomically.
// Latency 10 cycles tick-to-update_done; no backpressure, ticks arriving outside IDLE are dropped.
module kart_controller #(
    parameter logic [10:0] INIT_X      = 11'd1024,
    parameter logic [10:0] INIT_Y      = 11'd1024,
    parameter logic [8:0]  INIT_DIR    = 9'd90,
    parameter int          TURN_STEP   = 4,
    parameter logic [6:0]  MAX_SPEED   = 7'd64,
    parameter logic [6:0]  SAND_MAX    = 7'd16,
    parameter int          SPIN_FRAMES = 30,
    parameter int          SPIN_STEP   = 12
) (
    input  logic            clk_in,
    input  logic            rst_in_n,
    kart_controller_if.slave kif
);

    localparam logic [8:0]        TURN_S    = 9'(TURN_STEP % 360);
    localparam logic [8:0]        SPIN_S    = 9'(SPIN_STEP % 360);
    localparam int                SPIN_W    = $clog2(SPIN_FRAMES + 1);
    localparam logic [SPIN_W-1:0] SPIN_LOAD = SPIN_W'(SPIN_FRAMES);
    localparam logic [18:0]       POS_MAX   = {11'd2047, 8'd0};

    typedef enum logic [2:0] {IDLE, TURN, TRIG, SPEED, MOVE, TRACK, COMMIT} state_t;

    // Position is 11.8 fixed point; speed in 1/16 px per frame.
    typedef struct packed {
        logic [8:0]  dir;
        logic [18:0] x;
        logic [18:0] y;
        logic [6:0]  spd;
    } kart_t;

    localparam kart_t KART_INIT = '{dir: INIT_DIR, x: {INIT_X, 8'd0}, y: {INIT_Y, 8'd0}, spd: 7'd0};

    state_t             state;
    logic [1:0]         phase;
    kart_t              cur;
    kart_t              pend;
    logic signed [10:0] cos_r;
    logic signed [10:0] sin_r;
    logic [3:0]         terrain_r;
    logic               prev_on_finish;
    logic               oil_hit;
    logic [3:0]         lap_pend;
    logic [3:0]         lap_r;
    logic [SPIN_W-1:0]  spin_cnt;
    logic               spin_r;
    logic               done_r;
    logic [8:0]         cos_addr_r;
    logic [8:0]         sin_addr_r;
    logic [7:0]         track_addr_r;

    function automatic logic [8:0] dir_up(input logic [8:0] d, input logic [8:0] s);
        logic [9:0] t;
        t = {1'b0, d} + {1'b0, s};
        if (t >= 10'd360) t = t - 10'd360;
        return t[8:0];
    endfunction

    function automatic logic [8:0] dir_down(input logic [8:0] d, input logic [8:0] s);
        logic [9:0] t;
        if (d >= s) t = {1'b0, d - s};
        else        t = {1'b0, d} + 10'd360 - {1'b0, s};
        return t[8:0];
    endfunction

    // Bit 20 set means the sum went negative; bit 19 means it passed 2047.xx px.
    function automatic logic [18:0] clamp_pos(input logic [20:0] v);
        if (v[20])      return 19'd0;
        else if (v[19]) return POS_MAX;
        else            return v[18:0];
    endfunction

    logic [8:0] turn_dir;
    logic [8:0] sin_addr_c;

    always_comb begin
        turn_dir = cur.dir;
        if (spin_r)                              turn_dir = dir_up(cur.dir, SPIN_S);
        else if (kif.btn_left && !kif.btn_right) turn_dir = dir_up(cur.dir, TURN_S);
        else if (kif.btn_right && !kif.btn_left) turn_dir = dir_down(cur.dir, TURN_S);
        sin_addr_c = (turn_dir > 9'd90) ? turn_dir - 9'd90 : 9'd90 - turn_dir;
    end

    logic [7:0] spd_ext;
    logic [6:0] spd_cap;
    logic [6:0] spd_c;

    always_comb begin
        spd_ext = {1'b0, cur.spd};
        if (spin_r)             spd_ext = (spd_ext >= 8'd2) ? spd_ext - 8'd2 : 8'd0;
        else if (kif.btn_brake) spd_ext = (spd_ext >= 8'd4) ? spd_ext - 8'd4 : 8'd0;
        else if (kif.btn_accel) spd_ext = spd_ext + 8'd1;
        else                    spd_ext = (spd_ext != 8'd0) ? spd_ext - 8'd1 : 8'd0;
        spd_cap = (terrain_r == 4'd1) ? SAND_MAX : MAX_SPEED;
        spd_c   = (spd_ext > {1'b0, spd_cap}) ? spd_cap : spd_ext[6:0];
    end

    logic signed [18:0] spd_s;
    logic signed [18:0] cos_ext;
    logic signed [18:0] sin_ext;
    logic signed [18:0] prod_x;
    logic signed [18:0] prod_y;
    logic signed [18:0] dx;
    logic signed [18:0] dy;
    logic [20:0]        sum_x;
    logic [20:0]        sum_y;
    logic [18:0]        x_c;
    logic [18:0]        y_c;

    // speed * trig(x512) >>> 5 lands directly in 1/256 px.
    always_comb begin
        spd_s   = {12'd0, pend.spd};
        cos_ext = {{8{cos_r[10]}}, cos_r};
        sin_ext = {{8{sin_r[10]}}, sin_r};
        prod_x  = spd_s * cos_ext;
        prod_y  = spd_s * sin_ext;
        dx      = prod_x >>> 5;
        dy      = prod_y >>> 5;
        sum_x   = {2'b00, cur.x} + {{2{dx[18]}}, dx};
        sum_y   = {2'b00, cur.y} + {{2{dy[18]}}, dy};
        x_c     = clamp_pos(sum_x);
        y_c     = clamp_pos(sum_y);
    end

    logic [SPIN_W-1:0] spin_nxt;

    always_comb begin
        spin_nxt = '0;
        if (oil_hit)              spin_nxt = SPIN_LOAD;
        else if (spin_cnt != '0)  spin_nxt = spin_cnt - SPIN_W'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state          <= IDLE;
            phase          <= 2'd0;
            cur            <= KART_INIT;
            pend           <= KART_INIT;
            cos_r          <= '0;
            sin_r          <= '0;
            terrain_r      <= 4'd0;
            prev_on_finish <= 1'b0;
            oil_hit        <= 1'b0;
            lap_pend       <= 4'd0;
            lap_r          <= 4'd0;
            spin_cnt       <= '0;
            spin_r         <= 1'b0;
            done_r         <= 1'b0;
            cos_addr_r     <= 9'd0;
            sin_addr_r     <= 9'd0;
            track_addr_r   <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (kif.frame_tick) state <= TURN;
                end
                TURN: begin
                    pend.dir   <= turn_dir;
                    cos_addr_r <= turn_dir;
                    sin_addr_r <= sin_addr_c;
                    phase      <= 2'd0;
                    state      <= TRIG;
                end
                TRIG: begin
                    if (phase == 2'd2) begin
                        cos_r <= kif.cos_in;
                        sin_r <= kif.sin_in;
                        state <= SPEED;
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                SPEED: begin
                    pend.spd <= spd_c;
                    state    <= MOVE;
                end
                MOVE: begin
                    pend.x       <= x_c;
                    pend.y       <= y_c;
                    track_addr_r <= {y_c[18:15], x_c[18:15]};
                    phase        <= 2'd0;
                    state        <= TRACK;
                end
                TRACK: begin
                    if (phase == 2'd2) begin
                        terrain_r      <= kif.terrain_in;
                        prev_on_finish <= (kif.obstacle_in == 4'd5);
                        oil_hit        <= (kif.obstacle_in == 4'd6) && !spin_r;
                        // A lap counts only on the rising edge of being on the line while moving.
                        if (kif.obstacle_in == 4'd5 && !prev_on_finish &&
                            pend.spd != 7'd0 && lap_r != 4'hF)
                            lap_pend <= lap_r + 4'd1;
                        else
                            lap_pend <= lap_r;
                        state <= COMMIT;
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                COMMIT: begin
                    cur      <= pend;
                    lap_r    <= lap_pend;
                    spin_cnt <= spin_nxt;
                    spin_r   <= (spin_nxt != '0);
                    oil_hit  <= 1'b0;
                    done_r   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.direction     = cur.dir;
    assign kif.player_x      = cur.x[18:8];
    assign kif.player_y      = cur.y[18:8];
    assign kif.speed_out     = cur.spd;
    assign kif.lap_count     = lap_r;
    assign kif.spinning      = spin_r;
    assign kif.update_done   = done_r;
    assign kif.trig_cos_addr = cos_addr_r;
    assign kif.trig_sin_addr = sin_addr_r;
    assign kif.track_addr    = track_addr_r;

endmodule
